fifo4x16: RTL

Four-entry, 16-bit first-word-fall-through FIFO that buffers words ahead of the `mux4way16` read path. Its four storage registers drive the `a`/`b`/`c`/`d` inputs of a `mux4way16` instance, and the 2-bit read pointer drives `sel`. The block decouples a bursty 16-bit producer from a consumer that takes one word per cycle.

---
 rtl/fifo4x16_pkg.sv | 13 +
 rtl/fifo4x16_if.sv | 25 ++
 rtl/mux4way16.sv | 22 ++
 rtl/fifo4x16.sv | 74 +++++++
 4 files changed

// File: rtl/fifo4x16_pkg.sv
// Shared sizing and types for the 4x16 first-word-fall-through FIFO.
package fifo4x16_pkg;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = 2;
  localparam int unsigned FIFO_CNT_W = 3;
  localparam int unsigned WORD_W     = 16;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [FIFO_PTR_W-1:0] ptr_t;
  typedef logic [FIFO_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fifo4x16_if.sv
// Producer/consumer handshake and status bundle for fifo4x16.
interface fifo4x16_if;
  import fifo4x16_pkg::*;

  word_t in;
  logic  push;
  logic  pop;
  word_t out;
  logic  empty;
  logic  full;
  cnt_t  count;
  logic  overflow;
  logic  underflow;

  modport master (
    output in, push, pop,
    input  out, empty, full, count, overflow, underflow
  );

  modport slave (
    input  in, push, pop,
    output out, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/mux4way16.sv
// 16-bit four-way selector used as the FIFO read path.
module mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // select one of four words
  always_comb begin
    out = a;
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/fifo4x16.sv
// Four-entry, 16-bit first-word-fall-through FIFO; head word is read
// combinationally from storage through mux4way16 selected by rd_ptr.
module fifo4x16
  import fifo4x16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fifo4x16_if.slave  bus
);

  word_t mem0, mem1, mem2, mem3;
  ptr_t  wr_ptr, rd_ptr;
  cnt_t  count_q, count_nxt;
  logic  empty_q, full_q, overflow_q, underflow_q;
  logic  push_ok, pop_ok;
  logic [FIFO_DEPTH-1:0] we;

  // accept decisions use the flags registered at the start of the cycle
  assign push_ok = bus.push & ~full_q;
  assign pop_ok  = bus.pop & ~empty_q;

  // one-hot storage load decoded from wr_ptr
  assign we = push_ok ? (FIFO_DEPTH'(1) << wr_ptr) : '0;

  // occupancy after this edge; full/empty are registered from it
  assign count_nxt = (push_ok & ~pop_ok) ? count_q + FIFO_CNT_W'(1) :
                     (pop_ok & ~push_ok) ? count_q - FIFO_CNT_W'(1) :
                                           count_q;

  // all sequential state: storage, pointers, occupancy and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0        <= '0;
      mem1        <= '0;
      mem2        <= '0;
      mem3        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we[0]) mem0 <= bus.in;
      if (we[1]) mem1 <= bus.in;
      if (we[2]) mem2 <= bus.in;
      if (we[3]) mem3 <= bus.in;
      if (push_ok) wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      count_q <= count_nxt;
      empty_q <= (count_nxt == FIFO_CNT_W'(0));
      full_q  <= (count_nxt == FIFO_CNT_W'(FIFO_DEPTH));
      if (bus.push & full_q)  overflow_q  <= 1'b1;
      if (bus.pop  & empty_q) underflow_q <= 1'b1;
    end
  end

  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  mux4way16 u_rd_mux (
    .a   (mem0),
    .b   (mem1),
    .c   (mem2),
    .d   (mem3),
    .sel (rd_ptr),
    .out (bus.out)
  );

endmodule
